// File: rtl/weight_stream_sequencer_pkg.sv
// Shared constants and types for the weight stream sequencer: stream width, target IDs,
// FSM state encoding.
package weight_stream_sequencer_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 64;
    localparam int unsigned NUM_TARGETS     = 5;

    localparam logic [3:0] L1_CORE0 = 4'd0;
    localparam logic [3:0] L1_CORE1 = 4'd1;
    localparam logic [3:0] L1_CORE2 = 4'd2;
    localparam logic [3:0] L1_CORE3 = 4'd3;
    localparam logic [3:0] L2       = 4'd4;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StAddrRst,
        StStream,
        StDone
    } state_e;

    function automatic logic [NUM_TARGETS-1:0] target_onehot(input logic [3:0] id);
        return NUM_TARGETS'(1) << id;
    endfunction

endpackage

// File: rtl/weight_stream_sequencer_if.sv
// AXI-Stream weight channel between the sequencer (master) and the conv top level (slave).
interface weight_stream_sequencer_if;
    import weight_stream_sequencer_pkg::*;

    logic                       tvalid;
    logic                       tready;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/weight_stream_sequencer_axis_prefetch_fifo2.sv
// Two-entry prefetch FIFO; the head entry is a register that drives the stream output directly.
module axis_prefetch_fifo2 #(
    parameter int unsigned Width = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data,
    output logic [1:0]       count
);

    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       slot;
    logic             pop;
    logic             push;

    assign pop  = (count_q != 2'd0) && out_ready;
    assign push = in_valid && ((count_q != 2'd2) || pop);
    // Slot the incoming word lands in once this cycle's pop has shifted the tail forward.
    assign slot = count_q - {1'b0, pop};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (slot == 2'd0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;

endmodule

// File: rtl/weight_stream_sequencer.sv
// Walks a target mask in ascending order; for each target pulses the BRAM address reset and
// streams that target's words from source memory through a 2-entry prefetch FIFO.
module weight_stream_sequencer
    import weight_stream_sequencer_pkg::*;
#(
    parameter int unsigned WORDS_PER_TARGET = 72,
    parameter int unsigned SRC_ADDR_WIDTH   = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [NUM_TARGETS-1:0]     i_target_mask,
    input  logic [SRC_ADDR_WIDTH-1:0]  i_src_base,
    output logic                       o_mem_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0]  o_mem_rd_addr,
    input  logic [AXIS_DATA_WIDTH-1:0] i_mem_rd_data,
    weight_stream_sequencer_if.master  m_axis_w,
    output logic                       o_load_weights,
    output logic [3:0]                 o_target_layer,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned WordCntWidth = $clog2(WORDS_PER_TARGET + 1);
    localparam logic [WordCntWidth-1:0] NumWords = WordCntWidth'(WORDS_PER_TARGET);
    localparam logic [WordCntWidth-1:0] LastWord = WordCntWidth'(WORDS_PER_TARGET - 1);

    state_e                    state_q, state_d;
    logic [NUM_TARGETS-1:0]    mask_q, mask_d;
    logic [SRC_ADDR_WIDTH-1:0] base_q, base_d;
    logic [3:0]                tgt_q, tgt_d;
    logic [WordCntWidth-1:0]   issued_q, issued_d;
    logic                      inflight_q;
    logic                      inflight_last_q;

    logic                      fifo_valid;
    logic [AXIS_DATA_WIDTH:0]  fifo_data;
    logic [1:0]                fifo_count;
    logic                      pop;
    logic [2:0]                occupancy;
    logic                      rd_en;
    logic                      found;
    logic [3:0]                next_tgt;

    // Lowest selected target wins.
    always_comb begin
        found    = 1'b1;
        next_tgt = L1_CORE0;
        if (|(mask_q & target_onehot(L1_CORE0))) begin
            next_tgt = L1_CORE0;
        end else if (|(mask_q & target_onehot(L1_CORE1))) begin
            next_tgt = L1_CORE1;
        end else if (|(mask_q & target_onehot(L1_CORE2))) begin
            next_tgt = L1_CORE2;
        end else if (|(mask_q & target_onehot(L1_CORE3))) begin
            next_tgt = L1_CORE3;
        end else if (|(mask_q & target_onehot(L2))) begin
            next_tgt = L2;
        end else begin
            found = 1'b0;
        end
    end

    assign pop = fifo_valid && m_axis_w.tready;
    // Credit counts the slot freed by this cycle's pop so a ready sink sees one word per cycle.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign rd_en = (state_q == StStream) && (occupancy < 3'd2) && (issued_q < NumWords);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        base_d   = base_q;
        tgt_d    = tgt_q;
        issued_d = issued_q;
        if (rd_en) begin
            issued_d = issued_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    mask_d  = i_target_mask;
                    base_d  = i_src_base;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (found) begin
                    tgt_d   = next_tgt;
                    mask_d  = mask_q & ~target_onehot(next_tgt);
                    state_d = StAddrRst;
                end else begin
                    state_d = StDone;
                end
            end
            StAddrRst: begin
                issued_d = '0;
                state_d  = StStream;
            end
            StStream: begin
                if (pop && fifo_data[AXIS_DATA_WIDTH]) begin
                    state_d = StSelect;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            mask_q          <= '0;
            base_q          <= '0;
            tgt_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            mask_q          <= mask_d;
            base_q          <= base_d;
            tgt_q           <= tgt_d;
            issued_q        <= issued_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && (issued_q == LastWord);
        end
    end

    axis_prefetch_fifo2 #(
        .Width (AXIS_DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_q),
        .in_data   ({inflight_last_q, i_mem_rd_data}),
        .out_valid (fifo_valid),
        .out_ready (m_axis_w.tready),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    assign o_mem_rd_en   = rd_en;
    assign o_mem_rd_addr = base_q + SRC_ADDR_WIDTH'(32'(tgt_q) * WORDS_PER_TARGET)
                         + SRC_ADDR_WIDTH'(issued_q);

    assign m_axis_w.tvalid = fifo_valid;
    assign m_axis_w.tdata  = fifo_data[AXIS_DATA_WIDTH-1:0];
    assign m_axis_w.tlast  = fifo_valid && fifo_data[AXIS_DATA_WIDTH];

    assign o_load_weights = (state_q == StAddrRst);
    assign o_target_layer = tgt_q;
    assign o_busy         = (state_q != StIdle) && (state_q != StDone);
    assign o_done         = (state_q == StDone);

endmodule

// File: tb/tb_weight_stream_sequencer.sv
// Directed and randomized jobs against a list-based model of the expected weight stream.
module tb_weight_stream_sequencer;
    import weight_stream_sequencer_pkg::*;

    localparam int unsigned WPT = 72;
    localparam int unsigned AW  = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [4:0]    i_target_mask = '0;
    logic [AW-1:0] i_src_base = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [63:0]   mem_rd_data;
    logic          load_weights;
    logic [3:0]    target_layer;
    logic          busy;
    logic          done;

    weight_stream_sequencer_if axis_if ();

    weight_stream_sequencer #(
        .WORDS_PER_TARGET (WPT),
        .SRC_ADDR_WIDTH   (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_target_mask  (i_target_mask),
        .i_src_base     (i_src_base),
        .o_mem_rd_en    (mem_rd_en),
        .o_mem_rd_addr  (mem_rd_addr),
        .i_mem_rd_data  (mem_rd_data),
        .m_axis_w       (axis_if.master),
        .o_load_weights (load_weights),
        .o_target_layer (target_layer),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [68:0] got_q[$];
    logic [68:0] exp_q[$];
    logic [3:0]  lw_q[$];
    logic [3:0]  exp_lw_q[$];
    int          rd_cnt;
    int          done_cnt;
    int          stall_viol;
    bit          ready_rand = 1'b0;

    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {a, 4'h0, ~a, 4'h5, a, 8'h3C, ~a};
    endfunction

    // Source memory: one-cycle read latency.
    always_ff @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_word(mem_rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    initial begin
        axis_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axis_if.tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes, load pulses, reads, done pulses and stall stability.
    initial begin
        bit          prev_stall;
        logic [64:0] prev_word;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!axis_if.tvalid ||
                    {axis_if.tlast, axis_if.tdata} !== prev_word)) begin
                    stall_viol++;
                end
                prev_stall = axis_if.tvalid && !axis_if.tready;
                prev_word  = {axis_if.tlast, axis_if.tdata};
                if (axis_if.tvalid && axis_if.tready) begin
                    got_q.push_back({target_layer, axis_if.tlast, axis_if.tdata});
                end
                if (load_weights) lw_q.push_back(target_layer);
                if (mem_rd_en) rd_cnt++;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popcount5(input logic [4:0] m);
        int c = 0;
        for (int k = 0; k < 5; k++) if (m[k]) c++;
        return c;
    endfunction

    task automatic build_expected(input logic [4:0] mask, input logic [AW-1:0] base);
        exp_q.delete();
        exp_lw_q.delete();
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (mask[k]) begin
                exp_lw_q.push_back(4'(k));
                for (int w = 0; w < WPT; w++) begin
                    logic [AW-1:0] a;
                    a = AW'(int'(base) + k * WPT + w);
                    exp_q.push_back({4'(k), (w == WPT - 1), mem_word(a)});
                end
            end
        end
    endtask

    task automatic clear_monitor();
        got_q.delete();
        lw_q.delete();
        rd_cnt     = 0;
        done_cnt   = 0;
        stall_viol = 0;
    endtask

    task automatic compare_results(input string tag);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad >= 0) $display("first differing word index %0d", first_bad);
        check({tag, "_word_errs"}, 64'(bad), 64'd0);
        bad = (lw_q.size() != exp_lw_q.size()) ? 1 : 0;
        for (int i = 0; i < lw_q.size() && i < exp_lw_q.size(); i++) begin
            if (lw_q[i] !== exp_lw_q[i]) bad++;
        end
        check({tag, "_load_pulses"}, 64'(bad), 64'd0);
        check({tag, "_reads"}, 64'(rd_cnt), 64'(exp_q.size()));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_stall_stable"}, 64'(stall_viol), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_job(input string tag, input logic [4:0] mask, input logic [AW-1:0] base,
                           input bit rnd, input bit restart, output int lat, output int last_cyc);
        ready_rand = rnd;
        clear_monitor();
        build_expected(mask, base);
        @(posedge clk);
        #3;
        i_start       = 1'b1;
        i_target_mask = mask;
        i_src_base    = base;
        lat      = -1;
        last_cyc = -1;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk);
            #3;
            i_start = 1'b0;
            if (n == 1) check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
            if (restart && n == 40) begin
                i_start       = 1'b1;
                i_target_mask = 5'b00001;
                i_src_base    = 12'h300;
            end
            if (axis_if.tvalid && axis_if.tready && axis_if.tlast && last_cyc < 0) last_cyc = n;
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(lat > 0), 64'd1);
        repeat (3) @(posedge clk);
        #3;
        compare_results(tag);
    endtask

    initial begin
        int          lat;
        int          last_cyc;
        logic [4:0]  rmask;
        logic [AW-1:0] rbase;
        bit          reached;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("rst_tdata", axis_if.tdata, 64'd0);
        check("rst_tlast", 64'(axis_if.tlast), 64'd0);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        check("rst_load", 64'(load_weights), 64'd0);
        check("rst_target", 64'(target_layer), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        rst_n = 1'b1;

        run_job("one_target", 5'b00001, 12'd0, 1'b0, 1'b0, lat, last_cyc);
        check("one_target_latency", 64'(lat), 64'(2 + (WPT + 4)));
        check("one_target_tlast_cycle", 64'(last_cyc), 64'(WPT + 4));

        run_job("two_targets", 5'b10010, 12'd100, 1'b0, 1'b0, lat, last_cyc);
        check("two_targets_latency", 64'(lat), 64'(2 + 2 * (WPT + 4)));
        check("two_targets_last_layer", 64'(target_layer), 64'd4);

        run_job("backpressure", 5'b00001, 12'd0, 1'b1, 1'b0, lat, last_cyc);

        run_job("wrap", 5'b10111, 12'd4000, 1'b1, 1'b0, lat, last_cyc);

        run_job("empty", 5'b00000, 12'd55, 1'b0, 1'b0, lat, last_cyc);
        check("empty_latency", 64'(lat), 64'd2);

        run_job("restart", 5'b01000, 12'd7, 1'b0, 1'b1, lat, last_cyc);
        check("restart_latency", 64'(lat), 64'(2 + (WPT + 4)));

        for (int j = 0; j < 2; j++) begin
            rmask = 5'($urandom_range(1, 31));
            rbase = AW'($urandom);
            run_job($sformatf("rand%0d", j), rmask, rbase, 1'b0, 1'b0, lat, last_cyc);
            check($sformatf("rand%0d_latency", j), 64'(lat),
                  64'(2 + popcount5(rmask) * (WPT + 4)));
        end

        // Abort mid-way through target 2, then reload target 2 from scratch.
        ready_rand = 1'b0;
        clear_monitor();
        @(posedge clk);
        #3;
        i_start       = 1'b1;
        i_target_mask = 5'b00110;
        i_src_base    = 12'd50;
        reached = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #3;
            i_start = 1'b0;
            if (got_q.size() >= WPT + 30) begin
                reached = 1'b1;
                break;
            end
        end
        check("abort_reached_word30", 64'(reached), 64'd1);
        check("abort_layer_before", 64'(target_layer), 64'd2);
        rst_n = 1'b0;
        #1;
        check("abort_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("abort_tdata", axis_if.tdata, 64'd0);
        check("abort_tlast", 64'(axis_if.tlast), 64'd0);
        check("abort_rd_en", 64'(mem_rd_en), 64'd0);
        check("abort_load", 64'(load_weights), 64'd0);
        check("abort_target", 64'(target_layer), 64'd0);
        check("abort_busy_done", 64'({busy, done}), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_job("after_abort", 5'b00100, 12'd50, 1'b0, 1'b0, lat, last_cyc);
        check("after_abort_latency", 64'(lat), 64'(2 + (WPT + 4)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
